// File: rtl/muldiv_pkg.sv
// Shared constants for the E-stage multiply/divide unit: op encodings, FSM states, sizes.
package muldiv_pkg;

  localparam int XLEN       = 32;
  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = $clog2(ITER_COUNT);

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned radix-2 datapath shared by shift-add multiply and restoring divide.
// {hi,lo} ends as the 64-bit product, or as {remainder, quotient}.
module muldiv_iter_core
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] hi_next,
  output logic [XLEN-1:0] lo_next
);

  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic            ge;

  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    shifted = {hi_q, lo_q[XLEN-1]};
    ge      = shifted >= {1'b0, b_q};
    if (is_div) begin
      // Shifted remainder is < 2*divisor, so the 32-bit difference is exact.
      hi_next = ge ? (shifted[XLEN-1:0] - b_q) : shifted[XLEN-1:0];
      lo_next = {lo_q[XLEN-2:0], ge};
    end else begin
      hi_next = sum[XLEN:1];
      lo_next = {sum[0], lo_q[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      hi_q <= '0;
      lo_q <= a;
      b_q  <= b;
    end else if (step) begin
      hi_q <= hi_next;
      lo_q <= lo_next;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M execute-stage multiply/divide unit: FSM, special cases and sign fix-up.
// MULDIV_FAST_MUL_EN: when defined, MUL* ops finish in one cycle on a 33x33 multiplier.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  flush_i,
  input  logic [14:12]          funct3_i,
  input  logic [DATA_WIDTH-1:0] op_a_i,
  input  logic [DATA_WIDTH-1:0] op_b_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        f3_q;
  logic              neg_q;
  logic [XLEN-1:0]   result_q;

  logic [2:0]        f3;
  logic              sgn_a, sgn_b, a_neg, b_neg, neg_d;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              div_zero, div_ovf, bypass;
  logic [XLEN-1:0]   bypass_val, final_val, res_d;
  logic [XLEN-1:0]   hi_next, lo_next;
  logic [2*XLEN-1:0] prod;
  logic              accept, load_res, step;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_p;
`endif

  function automatic logic [XLEN-1:0] fix32(input logic n, input logic [XLEN-1:0] v);
    return n ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] fix64(input logic n, input logic [2*XLEN-1:0] v);
    return n ? -v : v;
  endfunction

  assign f3 = funct3_i;

  // Start-cycle decode: operand signs, magnitudes and the cases that skip CALC
  always_comb begin
    sgn_a    = (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    sgn_b    = (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    a_neg    = sgn_a & op_a_i[XLEN-1];
    b_neg    = sgn_b & op_b_i[XLEN-1];
    abs_a    = fix32(a_neg, op_a_i);
    abs_b    = fix32(b_neg, op_b_i);
    neg_d    = (f3 == F3_REM) ? a_neg : (a_neg ^ b_neg);
    div_zero = f3[2] && (op_b_i == '0);
    div_ovf  = f3[2] && !f3[0] && (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_i == '1);
    bypass   = div_zero | div_ovf;
    if (div_zero) bypass_val = f3[1] ? op_a_i : '1;
    else          bypass_val = f3[1] ? '0 : op_a_i;
`ifdef MULDIV_FAST_MUL_EN
    fast_a = {{XLEN{a_neg}}, op_a_i};
    fast_b = {{XLEN{b_neg}}, op_b_i};
    fast_p = fast_a * fast_b;
    if (!f3[2]) begin
      bypass     = 1'b1;
      bypass_val = (f3 == F3_MUL) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
    end
`endif
  end

  // Sign fix-up on the core's final-iteration values, so DONE already holds the answer
  always_comb begin
    prod = fix64(neg_q, {hi_next, lo_next});
    case (f3_q)
      F3_MUL:                       final_val = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: final_val = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              final_val = fix32(neg_q, lo_next);
      default:                      final_val = fix32(neg_q, hi_next);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    load_res = 1'b0;
    step     = 1'b0;
    res_d    = final_val;
    case (state_q)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          accept = 1'b1;
          if (bypass) begin
            state_d  = S_DONE;
            load_res = 1'b1;
            res_d    = bypass_val;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        step = 1'b1;
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(ITER_COUNT - 1)) begin
          state_d  = S_DONE;
          load_res = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == S_CALC) ? cnt_q + CNT_W'(1) : '0;
      if (load_res) result_q <= res_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      f3_q  <= f3;
      neg_q <= neg_d;
    end
  end

  muldiv_iter_core u_core (
    .clk     (clk),
    .load    (accept),
    .step    (step),
    .is_div  (f3_q[2]),
    .a       (abs_a),
    .b       (abs_b),
    .hi_next (hi_next),
    .lo_next (lo_next)
  );

  assign busy_o   = ((state_q == S_IDLE) && start_i && !flush_i) || (state_q == S_CALC);
  assign done_o   = (state_q == S_DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed corner cases plus random ops
// compared against an arithmetic reference model.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_res;

  ex_muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start),
    .flush_i  (flush),
    .funct3_i (funct3),
    .op_a_i   (op_a),
    .op_b_i   (op_b),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    int          sa;
    int          sb;
    sa = a;
    sb = b;
    case (f)
      3'd0: begin p = {32'b0, a} * {32'b0, b};             return p[31:0];  end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b};       return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b};             return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return 33;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start an op at the next falling edge and follow it to its done pulse
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [31:0] exp;
    int          lat;
    int          n;
    int          bad_busy;
    exp      = ref_result(f, a, b);
    lat      = ref_latency(f, a, b);
    n        = 0;
    bad_busy = 0;
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    #1;
    check({tag, "/busy_start"}, 32'(busy), 32'd1);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (done) begin
        n = k;
        break;
      end
      if (!busy) bad_busy++;
    end
    check({tag, "/latency"}, 32'(n), 32'(lat));
    check({tag, "/result"}, result, exp);
    check({tag, "/busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "/busy_drops"}, 32'(bad_busy), 32'd0);
    @(negedge clk);
    #1;
    check({tag, "/done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "/result_held"}, result, exp);
    last_res = exp;
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    int          n;
    int          early_done;

    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'd0; op_a = '0; op_b = '0;
    last_res = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/done", 32'(done), 32'd0);
    check("reset/result", result, 32'd0);
    rst = 1'b0;

    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div_neg7_2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_neg7_2");
    run_op(3'd5, 32'd7, 32'd2, "divu_7_2");
    run_op(3'd5, 32'd5, 32'd0, "divu_by0");
    run_op(3'd7, 32'd5, 32'd0, "remu_by0");
    run_op(3'd4, 32'd5, 32'd0, "div_by0");
    run_op(3'd6, 32'hFFFF_FFF0, 32'd0, "rem_by0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    run_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, "divu_big");
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, "mul_neg");
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh_m1_m1");
    run_op(3'd1, 32'h8000_0000, 32'h7FFF_FFFF, "mulh_mix");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
    run_op(3'd6, 32'd7, 32'hFFFF_FFFE, "rem_pos_negdiv");

    // Flush in the middle of a divide: no completion, result untouched
    @(negedge clk);
    funct3 = 3'd4; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    early_done = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 10) flush = 1'b1;
      #1;
      if (done) early_done++;
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush/busy", 32'(busy), 32'd0);
    check("flush/done", 32'(done), 32'd0);
    check("flush/result_kept", result, last_res);
    check("flush/no_early_done", 32'(early_done), 32'd0);
    run_op(3'd4, 32'hFFFF_FF9C, 32'd7, "post_flush_div");

    // Reset mid-CALC with start held; the op restarts after reset releases
    @(negedge clk);
    funct3 = 3'd1; op_a = 32'h1234_5678; op_b = 32'h8765_4321; start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 5) rst = 1'b1;
    end
    @(negedge clk);
    #1;
    check("rst_mid/done", 32'(done), 32'd0);
    check("rst_mid/result", result, 32'd0);
    rst = 1'b0;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (done) begin
        n = k;
        break;
      end
    end
    check("rst_restart/latency", 32'(n), 32'(ref_latency(3'd1, 32'h1234_5678, 32'h8765_4321)));
    check("rst_restart/result", result, ref_result(3'd1, 32'h1234_5678, 32'h8765_4321));
    last_res = result;
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: a = $urandom_range(0, 100);
        default: ;
      endcase
      run_op(f, a, b, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port start_i, input, 1, a valid M-extension op in E stage (from the D/E register outputs).
REQ-005 SHALL have port flush_i, input, 1, E-stage flush (same cycle as the D/E clr).
REQ-006 SHALL have port funct3_i, input, [14:12], op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have ports op_a_i and op_b_i, input, DATA_WIDTH, forwarded rs1 and rs2 operands.
REQ-008 SHALL have port busy_o, output, 1, stall request to the hazard unit.
REQ-009 SHALL have port done_o, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port result_o, output, DATA_WIDTH, result; valid while done_o=1 and held until the next completion.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, DONE.
REQ-012 IDLE with start_i=1 and flush_i=0 (cycle T): latch funct3 and operands, clear the counter, enter CALC at T+1.
REQ-013 CALC SHALL run exactly 32 iterations (T+1..T+32), then enter DONE at T+33.
REQ-014 DONE SHALL drive done_o=1 and busy_o=0, then go to IDLE unconditionally; start_i is ignored in DONE and CALC.
REQ-015 busy_o SHALL be (state==IDLE & start_i & !flush_i) | (state==CALC); the start-cycle term is combinational.
REQ-016 Signed ops SHALL use an unsigned core on absolute values, with sign correction applied before DONE.
REQ-017 MUL SHALL return the low 32 bits; MULH/MULHSU/MULHU the high 32 bits of the signed×signed, signed×unsigned, and unsigned×unsigned 64-bit product.
REQ-018 Divide by zero SHALL bypass CALC (IDLE->DONE at T+1): DIV/DIVU give 0xFFFFFFFF; REM/REMU give op_a.
REQ-019 DIV 0x80000000 / 0xFFFFFFFF SHALL bypass CALC: DIV gives 0x80000000, REM gives 0.
REQ-020 Remainder SHALL take the dividend's sign; quotient truncates toward zero.
REQ-021 flush_i=1 in any state SHALL force IDLE next cycle; no done_o pulse; result_o unchanged.
REQ-022 flush_i and start_i together in IDLE: flush wins, no operation starts.

Reset
REQ-023 rst=1 SHALL force state IDLE, counter 0, result_o 0, done_o 0, busy_o 0 next cycle, overriding all inputs including mid-CALC.

Configuration
REQ-024 Macro MULDIV_FAST_MUL_EN defined: MUL* ops SHALL complete single-cycle (IDLE->DONE at T+1) via a combinational 33x33 multiplier; divide ops are unchanged.
REQ-025 Macro MULDIV_FAST_MUL_EN undefined: MUL* ops SHALL use the 32-cycle shift-add path through CALC per REQ-013.

Structure
REQ-026 Package muldiv_pkg SHALL hold the funct3 op constants, the FSM state encoding, XLEN=32, and ITER_COUNT=32.
REQ-027 Sub-module muldiv_iter_core SHALL hold the shared iterative shift/add-subtract datapath (accumulator, operand shift registers); the FSM, special-case detection, and sign fix-up stay in ex_muldiv_unit.

Verification
REQ-028 MULHU 0xFFFFFFFF×0xFFFFFFFF, start at T -> busy_o 1 over T..T+32, done_o at T+33, result 0xFFFFFFFE (fast build: done_o at T+1).
REQ-029 DIV 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD; REM gives 0xFFFFFFFF; DIVU 7/2 gives 3.
REQ-030 DIVU 5/0 -> done_o at T+1, result 0xFFFFFFFF; REMU 5/0 gives 5.
REQ-031 DIV 0x80000000/0xFFFFFFFF -> done_o at T+1, result 0x80000000; REM gives 0.
REQ-032 flush_i at T+10 mid-DIV -> IDLE at T+11, no done_o, result_o keeps its prior value, new start at T+12 accepted.
REQ-033 rst at T+5 mid-CALC -> next cycle busy_o=0, done_o=0, result_o=0; a held start_i restarts the operation once rst deasserts.
